// File: rtl/seq_divider_if.sv
// Divider request/result bundle: operands and start in, status and {remainder, quotient} out.
// master = requester (ALU side), slave = seq_divider.
interface seq_divider_if #(
   parameter int BITS = 32
);
   logic              start;
   logic [BITS-1:0]   dividend;
   logic [BITS-1:0]   divisor;
   logic              busy;
   logic              done;
   logic [BITS-1:0]   quotient;
   logic [BITS-1:0]   remainder;
   logic [2*BITS-1:0] div_result;
   logic              div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_result, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_result, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring radix-2 divider; done BITS+2 edges after the accepting edge (1 edge for divide-by-zero).
// No backpressure: start is sampled only in IDLE and ignored while busy; results hold until the next done.
module seq_divider #(
   parameter int BITS = 32
) (
   input logic          clock,
   input logic          clear,
   seq_divider_if.slave bus
);
   localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PREP = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [BITS-1:0] x_q;
   logic [BITS-1:0] y_q;
   logic [BITS-1:0] mag_y;
   logic [BITS-1:0] quo;
   logic [BITS-1:0] rem;
   logic            neg_q;
   logic            neg_r;
   logic            busy_q;
   logic            done_q;
   logic            dbz_q;
   logic [BITS-1:0] quot_out;
   logic [BITS-1:0] rem_out;
   logic [BITS:0]   shifted;
   logic [BITS:0]   diff;

   // One restoring step: bring in the next dividend bit and trial-subtract the divisor magnitude.
   always_comb begin
      shifted = {rem, quo[BITS-1]};
      diff    = shifted - {1'b0, mag_y};
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= IDLE;
         cnt      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         mag_y    <= '0;
         quo      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         quot_out <= '0;
         rem_out  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  x_q    <= bus.dividend;
                  y_q    <= bus.divisor;
                  busy_q <= 1'b1;
                  state  <= PREP;
               end
            end
            PREP: begin
               if (y_q == '0) begin
                  quot_out <= '1;
                  rem_out  <= x_q;
                  dbz_q    <= 1'b1;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end else begin
                  quo   <= x_q[BITS-1] ? -x_q : x_q;
                  mag_y <= y_q[BITS-1] ? -y_q : y_q;
                  rem   <= '0;
                  neg_q <= x_q[BITS-1] ^ y_q[BITS-1];
                  neg_r <= x_q[BITS-1];
                  cnt   <= CW'(BITS - 1);
                  state <= ITER;
               end
            end
            ITER: begin
               if (diff[BITS]) begin
                  rem <= shifted[BITS-1:0];
                  quo <= {quo[BITS-2:0], 1'b0};
               end else begin
                  rem <= diff[BITS-1:0];
                  quo <= {quo[BITS-2:0], 1'b1};
               end
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               // Most-negative / -1 needs no special case: the magnitude quotient wraps to itself.
               quot_out <= neg_q ? -quo : quo;
               rem_out  <= neg_r ? -rem : rem;
               dbz_q    <= 1'b0;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_out;
   assign bus.remainder   = rem_out;
   assign bus.div_result  = {rem_out, quot_out};
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized operands vs. an arithmetic model.
module tb_seq_divider;
   localparam int BITS = 32;
   localparam int LAT  = BITS + 2;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   seq_divider_if #(.BITS(BITS)) bus ();

   seq_divider #(.BITS(BITS)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain signed arithmetic with the two documented exceptions.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dbz, output int lat);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0; dbz = 1'b0; lat = LAT;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
         dbz = 1'b0; lat = LAT;
      end
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input bit poke);
      logic [31:0] eq, er;
      logic        edbz;
      int          elat;
      int          edges;
      model(a, b, eq, er, edbz, elat);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clock);
      @(negedge clock);
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      check({tag, ".busy"}, 64'(bus.busy), 64'd1);
      check({tag, ".done_low"}, 64'(bus.done), 64'd0);
      edges = 0;
      while (!bus.done && edges < 60) begin
         if (poke && edges == 9) begin
            bus.start    = 1'b1;
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
         end
         @(posedge clock);
         edges++;
         @(negedge clock);
         bus.start = 1'b0;
      end
      check({tag, ".latency"}, 64'(edges), 64'(elat));
      check({tag, ".quot"}, 64'(bus.quotient), 64'(eq));
      check({tag, ".rem"}, 64'(bus.remainder), 64'(er));
      check({tag, ".result"}, bus.div_result, {er, eq});
      check({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(edbz));
      check({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      int dones = 0;
      int busys = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (bus.done) dones++;
         if (bus.busy) busys++;
      end
      check({tag, ".no_done"}, 64'(dones), 64'd0);
      check({tag, ".no_busy"}, 64'(busys), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"}, 64'(bus.busy), 64'd0);
      check({tag, ".done"}, 64'(bus.done), 64'd0);
      check({tag, ".quot"}, 64'(bus.quotient), 64'd0);
      check({tag, ".rem"}, 64'(bus.remainder), 64'd0);
      check({tag, ".result"}, bus.div_result, 64'd0);
      check({tag, ".dbz"}, 64'(bus.div_by_zero), 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      clear        = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_zero("reset");
      clear = 1'b0;

      run_div("p100_7", 32'd100, 32'd7, 1'b0);
      check("p100_7.const", bus.div_result, 64'h0000_0002_0000_000E);
      run_div("m100_7", -32'sd100, 32'd7, 1'b0);
      check("m100_7.const", bus.div_result, 64'hFFFF_FFFE_FFFF_FFF2);
      run_div("p100_m7", 32'd100, -32'sd7, 1'b0);
      check("p100_m7.const", bus.div_result, 64'h0000_0002_FFFF_FFF2);
      run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div("zero_num", 32'd0, 32'd5, 1'b0);
      run_div("div0", 32'd5, 32'd0, 1'b0);
      check("div0.const", bus.div_result, 64'h0000_0005_FFFF_FFFF);
      run_div("after_div0", 32'd77, 32'd3, 1'b0);
      run_div("poke_e10", 32'd1234567, -32'sd89, 1'b1);
      run_div("min_by_1", 32'h8000_0000, 32'd1, 1'b0);
      run_div("neg_small", -32'sd3, -32'sd7, 1'b0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom; b = 32'($signed($urandom_range(0, 40)) - 20); end
            2: begin a = 32'($signed($urandom_range(0, 2000)) - 1000); b = 32'd0; end
            3: begin a = 32'h8000_0000; b = (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom; end
            default: begin a = 32'($signed($urandom_range(0, 2000)) - 1000);
                           b = 32'($signed($urandom_range(1, 60)) - 30); end
         endcase
         run_div($sformatf("rnd%0d", i), a, b, 1'b0);
      end

      // Abort mid-operation: accept at E0, clear at E12.
      @(negedge clock);
      bus.start    = 1'b1;
      bus.dividend = 32'd1000;
      bus.divisor  = 32'd9;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (11) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      check_zero("clr_mid");
      expect_quiet("clr_mid", 40);

      // clear and start together: start is dropped.
      bus.start    = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd4;
      clear        = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      clear     = 1'b0;
      check_zero("clr_start");
      expect_quiet("clr_start", 40);

      run_div("post_clear", 32'd50, 32'd4, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
